// File: rtl/engine_rr_sched.sv
`default_nettype none
// engine_rr_sched: round-robin scheduler that shares one start/done engine among NREQ
// requesters, with a bounded WAIT timeout per job. Rev 1.0
module engine_rr_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [NREQ-1:0] err,
  output logic            eng_start,
  input  logic            eng_done,
  output logic            busy,
  output logic [IDW-1:0]  owner,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int              NSLOT      = 1 << IDW;
  localparam logic [7:0]      LAST_COUNT = 8'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  LAST_IDX   = IDW'(NREQ - 1);
  localparam logic [IDW:0]    NREQ_W     = (IDW + 1)'(NREQ);

  state_t           cur;
  logic [IDW-1:0]   ptr;
  logic [7:0]       cnt;
  logic [NSLOT-1:0] req_slots;
  logic [IDW:0]     slot;
  logic             found;
  logic [IDW-1:0]   winner;
  logic [NREQ-1:0]  owner_hot;
  logic [IDW-1:0]   next_ptr;

  // Pad req to a power-of-two width so an IDW-bit index is always in range.
  assign req_slots = NSLOT'(req);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    slot   = '0;
    for (int i = 0; i < NREQ; i++) begin
      slot = {1'b0, ptr} + (IDW + 1)'(i);
      if (slot >= NREQ_W) begin
        slot = slot - NREQ_W;
      end
      if (!found && req_slots[slot[IDW-1:0]]) begin
        found  = 1'b1;
        winner = slot[IDW-1:0];
      end
    end
  end

  assign owner_hot = NREQ'(1) << owner;
  assign next_ptr  = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur   <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      ack   <= '0;
      err   <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (cur)
        IDLE: begin
          if (found) begin
            owner <= winner;
            cur   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          cur <= WAIT;
        end
        WAIT: begin
          // done takes precedence over the final timeout count
          if (eng_done) begin
            ack <= owner_hot;
            cur <= RELEASE;
          end else if (cnt == LAST_COUNT) begin
            err <= owner_hot;
            cur <= RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: begin
          ptr <= next_ptr;
          cur <= IDLE;
        end
        default: cur <= IDLE;
      endcase
    end
  end

  assign state     = cur;
  assign busy      = (cur != IDLE);
  assign eng_start = (cur == ISSUE);

endmodule
`default_nettype wire
